// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - UART receiver pin and byte-output bundle (parity_err under UART_RX_PARITY_EN)
interface uart_rx_if;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;

  modport master (
    input  rxd,
    output rx_data, rx_valid, frame_err, busy, parity_err
  );

  modport slave (
    output rxd,
    input  rx_data, rx_valid, frame_err, busy, parity_err
  );
`else
  modport master (
    input  rxd,
    output rx_data, rx_valid, frame_err, busy
  );

  modport slave (
    output rxd,
    input  rx_data, rx_valid, frame_err, busy
  );
`endif
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver, 8E1 with parity_err when UART_RX_PARITY_EN is defined
module uart_rx #(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int BAUD        = 9600,
  parameter int SYNC_STAGES = 2
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.master bus
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxd_s;
  logic                   rxd_d;
  logic                   fall;

  state_t           state;
  logic [CNT_W-1:0] clk_cnt;
  logic [3:0]       bit_idx;
  logic [7:0]       shift_q;
  logic [7:0]       rx_data_q;
  logic             rx_valid_q;
  logic             frame_err_q;
  logic             busy_q;
`ifdef UART_RX_PARITY_EN
  logic             par_bit_q;
  logic             parity_err_q;
`endif

  assign rxd_s = sync_q[SYNC_STAGES-1];
  assign fall  = rxd_d & ~rxd_s;

  // Bring the asynchronous pin into the clock domain; preset high so reset looks like an idle line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      rxd_d  <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.rxd};
      rxd_d  <= rxd_s;
    end
  end

  // Frame FSM: mid-bit sampling driven by the clock counter, all outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (fall) begin
            state   <= S_START;
            clk_cnt <= '0;
            busy_q  <= 1'b1;
          end
        end

        S_START: begin
          if (clk_cnt == CNT_MID) begin
            clk_cnt <= '0;
            if (!rxd_s) begin
              state   <= S_DATA;
              bit_idx <= '0;
            end else begin
              // Line came back high before mid start bit: treat as a glitch
              state  <= S_IDLE;
              busy_q <= 1'b0;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end

        S_DATA: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt <= '0;
            shift_q <= {rxd_s, shift_q[7:1]};
            bit_idx <= bit_idx + 4'd1;
            if (bit_idx == 4'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end

`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt   <= '0;
            par_bit_q <= rxd_s;
            state     <= S_STOP;
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
`endif

        S_STOP: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt <= '0;
            if (rxd_s) begin
              state  <= S_IDLE;
              busy_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
              // Even parity: data bits plus parity bit must XOR to zero
              if ((^shift_q) ^ par_bit_q) begin
                parity_err_q <= 1'b1;
              end else begin
                rx_data_q  <= shift_q;
                rx_valid_q <= 1'b1;
              end
`else
              rx_data_q  <= shift_q;
              rx_valid_q <= 1'b1;
`endif
            end else begin
              // Bad stop bit outranks any parity result; park until the line recovers
              frame_err_q <= 1'b1;
              state       <= S_BREAK;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end

        S_BREAK: begin
          if (rxd_s) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end
        end

        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = busy_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx at 10 clocks per bit
module tb_uart_rx;

  localparam int CPB = 10;

  typedef struct {
    int         kind;   // 0 good byte, 1 frame error, 2 parity error
    logic [7:0] data;   // rx_data expected while the pulse is high
    int         start;  // cycle at which the start bit was driven
    int         lat;    // expected cycles from start edge to pulse
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   errors;
  int   checks;

  exp_t       q[$];
  logic [7:0] model_last;
  exp_t       e;
  int         kind_seen;
  int         lat_seen;
  logic       pulse;
  logic       prev_pulse;

  uart_rx_if bus();

  uart_rx #(
    .CLK_FREQ   (1_000_000),
    .BAUD       (100_000),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation ran past the time limit (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  // Monitor: pop the scoreboard whenever the DUT reports a frame outcome
  always @(negedge clk) begin
    if (rst) begin
      prev_pulse = 1'b0;
    end else begin
`ifdef UART_RX_PARITY_EN
      pulse = bus.rx_valid | bus.frame_err | bus.parity_err;
      kind_seen = bus.rx_valid ? 0 : (bus.frame_err ? 1 : 2);
`else
      pulse = bus.rx_valid | bus.frame_err;
      kind_seen = bus.rx_valid ? 0 : 1;
`endif
      if (pulse) begin
        checks++;
        if (bus.rx_valid && bus.frame_err) begin
          errors++;
          $display("FAIL overlap: rx_valid=%0b frame_err=%0b, required not both high", bus.rx_valid, bus.frame_err);
        end
        checks++;
        if (prev_pulse) begin
          errors++;
          $display("FAIL double_pulse: pulse on consecutive cycles at cycle %0d, required single-cycle", cyc);
        end
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: kind=%0d rx_data=%02h at cycle %0d, required no pulse", kind_seen, bus.rx_data, cyc);
        end else begin
          e = q.pop_front();
          if (kind_seen != e.kind) begin
            errors++;
            $display("FAIL pulse_kind: got kind=%0d, required kind=%0d", kind_seen, e.kind);
          end
          checks++;
          if (bus.rx_data !== e.data) begin
            errors++;
            $display("FAIL rx_data: got %02h, required %02h", bus.rx_data, e.data);
          end
          checks++;
          lat_seen = cyc - e.start;
          if (lat_seen < e.lat - 1 || lat_seen > e.lat + 1) begin
            errors++;
            $display("FAIL latency: got %0d cycles, required %0d +-1", lat_seen, e.lat);
          end
        end
      end
      prev_pulse = pulse;
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_bit(input string name, input logic got, input logic req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0b, required %0b", name, got, req);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (bus.rx_data !== 8'h00 || bus.rx_valid !== 1'b0 || bus.frame_err !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: rx_data=%02h rx_valid=%0b frame_err=%0b busy=%0b, required 00/0/0/0",
               name, bus.rx_data, bus.rx_valid, bus.frame_err, bus.busy);
    end
`ifdef UART_RX_PARITY_EN
    check_bit({name, "_parity_err"}, bus.parity_err, 1'b0);
`endif
  endtask

  // Drive one frame on the pin and predict its outcome; par < 0 means no parity bit
  task automatic send_frame(input logic [7:0] d, input logic stop, input int par, input bit chk_busy);
    exp_t x;
    x.start = cyc;
    x.lat   = (par >= 0) ? 9 * CPB + CPB / 2 + 2 + CPB : 9 * CPB + CPB / 2 + 2;
    if (!stop) begin
      x.kind = 1;
      x.data = model_last;
    end else if (par >= 0 && (((^d) ^ par[0]) == 1'b1)) begin
      x.kind = 2;
      x.data = model_last;
    end else begin
      x.kind = 0;
      x.data = d;
      model_last = d;
    end
    q.push_back(x);
    bus.rxd = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin
      bus.rxd = d[i];
      wait_clks(CPB);
      if (chk_busy) check_bit("busy_in_frame", bus.busy, 1'b1);
    end
    if (par >= 0) begin
      bus.rxd = par[0];
      wait_clks(CPB);
    end
    bus.rxd = stop;
    wait_clks(CPB);
  endtask

  initial begin
    logic [7:0] d;
    logic       stop;
    bit         seen_idle;
    errors     = 0;
    checks     = 0;
    cyc        = 0;
    model_last = 8'h00;
    prev_pulse = 1'b0;
    rst        = 1'b1;
    bus.rxd    = 1'b1;

    wait_clks(3);
    check_reset_outputs("reset_state");
    rst = 1'b0;
    wait_clks(5);
    check_bit("idle_busy", bus.busy, 1'b0);

    // Single frame with busy watched throughout
    send_frame(8'hA5, 1'b1, -1, 1'b1);
    wait_clks(5);

    // Back-to-back frames, no idle gap
    send_frame(8'h00, 1'b1, -1, 1'b0);
    send_frame(8'hFF, 1'b1, -1, 1'b0);
    send_frame(8'h3C, 1'b1, -1, 1'b0);
    wait_clks(10);

    // Three-clock low glitch on an idle line
    bus.rxd = 1'b0;
    wait_clks(3);
    check_bit("glitch_busy_rise", bus.busy, 1'b1);
    bus.rxd = 1'b1;
    seen_idle = 1'b0;
    for (int i = 0; i < 6 && !seen_idle; i++) begin
      wait_clks(1);
      if (bus.busy == 1'b0) seen_idle = 1'b1;
    end
    check_bit("glitch_busy_fall", seen_idle, 1'b1);
    wait_clks(10);

    // Bad stop bit followed by a held-low break
    send_frame(8'h55, 1'b0, -1, 1'b0);
    wait_clks(50);
    bus.rxd = 1'b1;
    wait_clks(10);
    send_frame(8'h12, 1'b1, -1, 1'b0);
    wait_clks(5);

    // Reset during data bit 4 of 8'hC3
    d = 8'hC3;
    bus.rxd = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 4; i++) begin
      bus.rxd = d[i];
      wait_clks(CPB);
    end
    bus.rxd = d[4];
    wait_clks(CPB / 2);
    rst = 1'b1;
    model_last = 8'h00;
    wait_clks(1);
    check_reset_outputs("midframe_reset");
    wait_clks(3);
    bus.rxd = 1'b1;
    rst = 1'b0;
    wait_clks(20);
    send_frame(8'h7E, 1'b1, -1, 1'b0);
    wait_clks(5);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1, 1'b0);
    wait_clks(5);
    send_frame(8'h07, 1'b1, 0, 1'b0);
    wait_clks(5);
`endif

    // Randomized frames with occasional bad stop bits and random gaps
    for (int n = 0; n < 10; n++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
`ifdef UART_RX_PARITY_EN
      send_frame(d, stop, int'($urandom_range(0, 1)), 1'b0);
`else
      send_frame(d, stop, -1, 1'b0);
`endif
      if (!stop) begin
        wait_clks($urandom_range(0, 20));
        bus.rxd = 1'b1;
        wait_clks($urandom_range(2, 6));
      end else begin
        wait_clks($urandom_range(0, 4));
      end
    end

    wait_clks(40);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_pulses: %0d expected outcomes never seen, required 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: the receive end of the 8N1 serial link driven by the board's UART transmit path.
- Samples the asynchronous RXD pin, recovers one byte per frame and presents it with a single-cycle valid strobe.
- Flags malformed frames.
- Sits between the USB-UART bridge pin and downstream consumers such as display and LED logic, on the 100 MHz board clock.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD, 9600, line rate in bit/s.
- CLKS_PER_BIT, CLK_FREQ/BAUD (integer division; 10416 at defaults), clocks per bit period. Derived localparam, not overridable.
- SYNC_STAGES, 2, synchronizer flip-flops on rxd (legal range 2..3).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- rxd  input  1  serial line from pin, idle high, asynchronous to clk
- rx_data  output  8  last received byte, held until next good frame
- rx_valid  output  1  one-cycle pulse: rx_data updated with a good frame
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- busy  output  1  high while a frame is being received (any state except IDLE)

Behaviour:
- Reset: rx_data=8'h00, rx_valid=0, frame_err=0, busy=0. Synchronizer chain preset to 1 (line idle). FSM=IDLE, bit counter=0, clock counter=0.
- rxd passes through SYNC_STAGES flip-flops to give rxd_s. An extra register rxd_d gives the falling-edge detect (rxd_d=1 & rxd_s=0).
- IDLE:
  - falling edge on rxd_s -> START, clock counter cleared.
  - a line held low with no edge does not start a frame.
- START:
  - count to CLKS_PER_BIT/2-1 (mid start bit) and sample rxd_s.
  - sample 0 -> DATA, counter cleared, bit index 0.
  - sample 1 -> glitch, return to IDLE with no output pulse.
- DATA:
  - every CLKS_PER_BIT clocks, sample rxd_s into the shift register, LSB first.
  - after bit index 7 -> STOP (or PARITY when enabled).
- STOP:
  - after CLKS_PER_BIT clocks, sample rxd_s at mid stop bit.
  - sample 1 -> rx_data loaded with the shift register and rx_valid=1 in the same clock edge, then IDLE on the next cycle. A new start edge is accepted from the following cycle, so back-to-back frames are received.
  - sample 0 -> frame_err=1 for one cycle, rx_data unchanged, go to BREAK.
- BREAK: wait until rxd_s=1, then IDLE. A held-low line (break) gives exactly one frame_err.
- Latency: rx_valid asserts CLKS_PER_BIT/2 + 9*CLKS_PER_BIT clocks (±1) after the synchronized falling edge, plus SYNC_STAGES clocks from the pin.
- rx_valid and frame_err are never high in the same cycle and are never high for two consecutive cycles.
- Counter widths: clock counter sized $clog2(CLKS_PER_BIT) bits; bit index 4 bits. No wrap during a frame.
- Asynchronous rst mid-frame: the frame is abandoned, all outputs go to reset values immediately, no pulse is generated. After release the receiver waits for a fresh falling edge.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- When defined:
  - frame is 8E1; a PARITY state follows DATA and samples a 9th bit at mid-bit.
  - extra output parity_err (1 bit, reset 0).
  - if XOR of the 8 data bits and the parity bit = 1, pulse parity_err for one cycle at the stop-bit sample instead of rx_valid, and leave rx_data unchanged.
  - if the stop bit is also bad, frame_err takes priority: parity_err=0, and the FSM goes to BREAK.
- When undefined: 8N1 only, no parity_err port, no PARITY state.

Test Plan:
- Use CLK_FREQ=1_000_000 and BAUD=100_000 (10 clocks per bit).
- Send 8'hA5, 8N1 -> rx_valid one pulse ~97 clks after start edge, rx_data=8'hA5, frame_err=0, busy high throughout the frame.
- Send 8'h00, 8'hFF, 8'h3C back-to-back with no idle gap -> three rx_valid pulses, rx_data sequence 00, FF, 3C, no frame_err.
- Low glitch of 3 clocks on an idle line -> no rx_valid, no frame_err, busy returns to 0 within 5 clks after the glitch.
- Send 8'h55 with stop bit forced low, line then held low 50 clks, then high -> exactly one frame_err, rx_data keeps its prior value; a following 8'h12 frame is received correctly.
- Assert rst at data bit 4 of 8'hC3, release, send 8'h7E -> no pulse for the aborted frame, rx_valid with rx_data=8'h7E.
- With UART_RX_PARITY_EN: 8'h07 with parity bit 1 -> rx_valid and rx_data=8'h07; same byte with parity bit 0 -> parity_err pulse, no rx_valid.
